seq_deser_4x1b: RTL and testbench
=================================

SEQ_DESER_4X1B -- requirements
Module: seq_deser_4x1b

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  async active-high; clears all state immediately and independently of clk.
REQ-003 in_  input  1  serial data bit, one per cycle, LSB first, 4-bit frames, continuous, frame-aligned to reset release.
REQ-004 out_val  output  1  parallel word available at the head of the output buffer.
REQ-005 out_rdy  input  1  consumer accepts; a transfer occurs in a cycle where out_val and out_rdy are both 1.
REQ-006 out_data  output  4  head word; bit k is the serial bit received in frame slot k.
REQ-007 overflow  output  1  sticky dropped-word flag; present only under SEQ_DESER_4X1B_OVFL_EN.

Function
REQ-008 The block SHALL keep a 2-bit frame slot counter of 0..3 that increments every non-reset cycle and wraps from 3 to 0.
REQ-009 In slot k = 0..2, in_ SHALL be captured into shift-register bit k at the rising edge.
REQ-010 In slot 3, the word {in_, shreg[2:0]} SHALL be offered for enqueue at that edge; the counter SHALL return to 0.
REQ-011 The block SHALL buffer words in a 2-entry FIFO with FIFO ordering: the oldest word is at the head.
REQ-012 Enqueue-to-visible latency SHALL be 1 cycle: out_val rises in the cycle after slot 3; there is no combinational path from in_ to the outputs.
REQ-013 out_val SHALL equal FIFO not-empty; out_data SHALL be the head entry and SHALL be 4'b0000 whenever out_val=0.
REQ-014 Dequeue SHALL occur on any edge where out_val=1 and out_rdy=1.
REQ-015 An enqueue into a FIFO that is full but dequeuing in the same cycle SHALL be accepted; occupancy stays at 2.
REQ-016 An enqueue into a full FIFO with no dequeue in that cycle SHALL be dropped; the stored entries are unchanged.
REQ-017 Simultaneous enqueue and dequeue with occupancy 1 SHALL leave occupancy at 1, with the new word at the head.
REQ-018 out_val and out_data SHALL be stable while out_val=1 and out_rdy=0.
REQ-019 out_rdy SHALL be ignored while out_val=0.
REQ-020 Occupancy SHALL be an explicit 2-bit count of 0..2; the read and write pointers SHALL be 1 bit each and wrap.

Reset
REQ-021 While reset=1, the following SHALL hold: counter=0, shreg=0, FIFO empty, pointers=0, out_val=0, out_data=0, overflow=0.
REQ-022 Reset asserted mid-frame SHALL discard the partial word; the first cycle after release is slot 0.
REQ-023 Reset asserted with buffered words SHALL discard them; no transfer occurs in the reset cycle.

Configuration
REQ-024 With SEQ_DESER_4X1B_OVFL_EN defined:
- the overflow port SHALL exist.
- overflow SHALL be set to 1 at the edge that drops a word (REQ-016).
- overflow SHALL hold until reset.
REQ-025 Without SEQ_DESER_4X1B_OVFL_EN:
- the overflow port and its register SHALL be absent.
- drops SHALL still occur silently per REQ-016.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Reset, then in_ = 1,0,1,1 in slots 0..3 with out_rdy=1 -> out_val=1 with out_data=4'hD for exactly 1 cycle, starting in cycle 5.
- Back-to-back frames 4'h3, 4'hF, 4'h0 with out_rdy=1 -> out_val pulses with the same three words in order, 4 cycles apart.
- out_rdy=0 for frames 4'h1, 4'h2, 4'h3 -> occupancy 2, head stays 4'h1, 4'h3 dropped, overflow=1 (macro on); then out_rdy=1 -> outputs 4'h1, then 4'h2, then out_val=0.
- FIFO full with out_rdy=1 in the slot-3 cycle of frame 4'hA -> head dequeued, 4'hA accepted, overflow stays 0.
- reset pulsed after 2 bits of a frame, with 1 word buffered -> out_val=0 immediately; the next 4 bits 0,1,1,0 -> out_data=4'h6.
- Macro off -> the same overflow stimulus as the third scenario yields identical out_val and out_data, and no overflow port exists.

Source files
------------

// File: rtl/seq_deser_4x1b.sv
`default_nettype none
// ============================================================================
// seq_deser_4x1b : 1-bit serial to 4-bit parallel deserializer, 2-entry FIFO.
// Optional sticky drop flag under SEQ_DESER_4X1B_OVFL_EN.   Rev 1.0
// ============================================================================
module seq_deser_4x1b (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_,
    input  logic       out_rdy,
    output logic       out_val,
    output logic [3:0] out_data
`ifdef SEQ_DESER_4X1B_OVFL_EN
    ,
    output logic       overflow
`endif
);

    logic [1:0] slot;
    logic [2:0] shreg;
    logic [3:0] mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;

    logic       enq;
    logic       deq;
    logic       full;
    logic       accept;
    logic [3:0] word;

    assign enq    = (slot == 2'd3);
    assign word   = {in_, shreg};
    assign full   = (count == 2'd2);
    assign deq    = out_val & out_rdy;
    // A full FIFO still takes the new word when the head leaves on the same edge.
    assign accept = enq & (~full | deq);

    assign out_val  = (count != 2'd0);
    assign out_data = out_val ? mem[rd_ptr] : 4'b0000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot  <= 2'd0;
            shreg <= 3'd0;
        end else begin
            slot <= slot + 2'd1;
            case (slot)
                2'd0:    shreg[0] <= in_;
                2'd1:    shreg[1] <= in_;
                2'd2:    shreg[2] <= in_;
                default: shreg    <= shreg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= 4'd0;
            mem[1] <= 4'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({accept, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef SEQ_DESER_4X1B_OVFL_EN
    logic drop;
    assign drop = enq & full & ~deq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_deser_4x1b.sv
`default_nettype none
// ============================================================================
// tb_seq_deser_4x1b : scoreboard bench for seq_deser_4x1b.   Rev 1.0
// ============================================================================
module tb_seq_deser_4x1b;

    logic       clk;
    logic       reset;
    logic       in_;
    logic       out_rdy;
    logic       out_val;
    logic [3:0] out_data;
`ifdef SEQ_DESER_4X1B_OVFL_EN
    logic       overflow;
`endif

    int tests = 0;
    int fails = 0;
    bit started = 0;

    seq_deser_4x1b dut (
        .clk      (clk),
        .reset    (reset),
        .in_      (in_),
        .out_rdy  (out_rdy),
        .out_val  (out_val),
        .out_data (out_data)
`ifdef SEQ_DESER_4X1B_OVFL_EN
        ,
        .overflow (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame assembler plus a queue holding the buffered words.
    logic [3:0] exp_q [$];
    int         m_slot;
    int         m_word;
    bit         m_ovf;
    bit         m_deq;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_slot = 0;
            m_word = 0;
            m_ovf  = 0;
            exp_q.delete();
        end else begin
            m_deq  = (exp_q.size() != 0) && out_rdy;
            m_word = m_word + (int'(in_) << m_slot);
            if (m_deq) void'(exp_q.pop_front());
            if (m_slot == 3) begin
                if (exp_q.size() < 2) exp_q.push_back(m_word[3:0]);
                else                  m_ovf = 1;
                m_word = 0;
                m_slot = 0;
            end else begin
                m_slot++;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("out_val", int'(out_val), int'(exp_q.size() != 0));
            if (exp_q.size() != 0) check("out_data", int'(out_data), int'(exp_q[0]));
            else                   check("out_data_idle", int'(out_data), 0);
`ifdef SEQ_DESER_4X1B_OVFL_EN
            check("overflow", int'(overflow), int'(m_ovf));
`endif
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Bits of w are driven LSB first; r is the out_rdy used in slots 0..2, r3 in slot 3.
    task automatic frame(input logic [3:0] w, input logic r, input logic r3);
        for (int k = 0; k < 4; k++) begin
            in_     = w[k];
            out_rdy = (k == 3) ? r3 : r;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset   = 1'b1;
        in_     = 1'b0;
        out_rdy = 1'b0;
        @(posedge clk); #1;
        started = 1;
        check("reset_val", int'(out_val), 0);
        check("reset_data", int'(out_data), 0);
        do_reset();

        // Single word 4'hD, visible for one cycle at cycle 5.
        frame(4'hD, 1'b1, 1'b1);
        check("d_val", int'(out_val), 1);
        check("d_data", int'(out_data), 4'hD);
        in_ = 1'b0;
        @(posedge clk); #1;
        check("d_gone", int'(out_val), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Back-to-back frames drained continuously.
        frame(4'h3, 1'b1, 1'b1);
        frame(4'hF, 1'b1, 1'b1);
        frame(4'h0, 1'b1, 1'b1);
        frame(4'h0, 1'b1, 1'b1);

        // Overflow: third word dropped while consumer stalls.
        do_reset();
        frame(4'h1, 1'b0, 1'b0);
        frame(4'h2, 1'b0, 1'b0);
        frame(4'h3, 1'b0, 1'b0);
        check("ovf_head", int'(out_data), 4'h1);
`ifdef SEQ_DESER_4X1B_OVFL_EN
        check("ovf_flag", int'(overflow), 1);
`endif
        frame(4'h0, 1'b1, 1'b1);
        frame(4'h0, 1'b1, 1'b1);

        // Full FIFO with a dequeue on the enqueue edge accepts the word.
        do_reset();
        frame(4'h4, 1'b0, 1'b0);
        frame(4'h5, 1'b0, 1'b0);
        frame(4'hA, 1'b0, 1'b1);
        check("full_deq_head", int'(out_data), 4'h5);
`ifdef SEQ_DESER_4X1B_OVFL_EN
        check("full_deq_noovf", int'(overflow), 0);
`endif
        frame(4'h0, 1'b1, 1'b1);

        // Reset mid-frame with a buffered word.
        do_reset();
        frame(4'h5, 1'b0, 1'b0);
        in_ = 1'b1; @(posedge clk); #1;
        in_ = 1'b0; @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("midrst_val", int'(out_val), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        frame(4'h6, 1'b0, 1'b0);
        check("midrst_data", int'(out_data), 4'h6);
        frame(4'h0, 1'b1, 1'b1);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 800; c++) begin
            in_     = 1'($urandom_range(0, 1));
            out_rdy = ($urandom_range(0, 3) != 0);
            reset   = ($urandom_range(0, 99) == 0);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
